// File: rtl/next_sram_pkg.sv
// Shared types, default sizes and lane-mask helper for the banked next-pointer SRAM.
package next_sram_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam int DEF_ADDR_SPACE = 4;
   localparam int DEF_Q          = 16;
   localparam int DEF_BW         = 4;

   // Turns an active-low lane mask into active-high per-bit write enables.
   function automatic logic [DEF_BW*DEF_Q-1:0] lane_mask_expand(input logic [DEF_Q-1:0] mask_n);
      logic [DEF_BW*DEF_Q-1:0] bits;
      bits = '0;
      for (int i = 0; i < DEF_Q; i++) begin
         bits[i*DEF_BW +: DEF_BW] = {DEF_BW{~mask_n[i]}};
      end
      return bits;
   endfunction

endpackage

// File: rtl/next_sram_clr_fsm.sv
// Clear-sweep controller: walks every address once, flags writes rejected meanwhile.
module next_sram_clr_fsm
   import next_sram_pkg::*;
#(
   parameter int ADDR_SPACE = DEF_ADDR_SPACE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_start,
   input  logic                  wsb,
   output logic                  clr_sel,
   output logic [ADDR_SPACE-1:0] clr_ptr,
   output logic                  clr_busy,
   output logic                  wr_drop
);

   localparam logic [ADDR_SPACE-1:0] LAST_PTR = '1;

   clr_state_t            state_reg;
   logic [ADDR_SPACE-1:0] ptr_reg;
   logic                  drop_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         drop_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (clr_start) begin
                  state_reg <= CLEAR;
                  ptr_reg   <= '0;
                  drop_reg  <= 1'b0;
               end
            end
            default: begin
               // clr_start is deliberately ignored here: a sweep never restarts.
               if (!wsb) drop_reg <= 1'b1;
               if (ptr_reg == LAST_PTR) state_reg <= IDLE;
               else                     ptr_reg   <= ptr_reg + 1'b1;
            end
         endcase
      end
   end

   assign clr_sel  = (state_reg == CLEAR);
   assign clr_busy = (state_reg == CLEAR);
   assign clr_ptr  = ptr_reg;
   assign wr_drop  = drop_reg;

endmodule

// File: rtl/next_sram_banked.sv
// Lane-masked next-pointer SRAM with write-first bypass and clear sweep.
// Define NEXT_SRAM_OUT_REG_EN to add a second output register stage.
module next_sram_banked
   import next_sram_pkg::*;
#(
   parameter int            ADDR_SPACE = DEF_ADDR_SPACE,
   parameter int            Q          = DEF_Q,
   parameter int            BW         = DEF_BW,
   parameter logic [BW-1:0] INIT_VAL   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wsb,
   input  logic [BW*Q-1:0]       wdata,
   input  logic [Q-1:0]          bytemask,
   input  logic [ADDR_SPACE-1:0] waddr,
   input  logic                  ren,
   input  logic [ADDR_SPACE-1:0] raddr,
   output logic [BW*Q-1:0]       rdata,
   output logic                  rvalid,
   input  logic                  clr_start,
   output logic                  clr_busy,
   output logic                  wr_drop
);

   localparam int DEPTH = 2**ADDR_SPACE;
   localparam int W     = BW*Q;

   logic [W-1:0] mem [DEPTH];

   logic                  clr_sel;
   logic [ADDR_SPACE-1:0] clr_ptr;

   next_sram_clr_fsm #(.ADDR_SPACE(ADDR_SPACE)) u_clr_fsm (
      .clk       (clk),
      .rst       (rst),
      .clr_start (clr_start),
      .wsb       (wsb),
      .clr_sel   (clr_sel),
      .clr_ptr   (clr_ptr),
      .clr_busy  (clr_busy),
      .wr_drop   (wr_drop)
   );

   logic [W-1:0] wr_bits;

   generate
      if (Q == DEF_Q && BW == DEF_BW) begin : g_pkg_expand
         assign wr_bits = lane_mask_expand(bytemask);
      end else begin : g_gen_expand
         for (genvar gi = 0; gi < Q; gi++) begin : g_lane
            assign wr_bits[gi*BW +: BW] = {BW{~bytemask[gi]}};
         end
      end
   endgenerate

   logic                  wr_fire;
   logic                  rd_accept;
   logic                  rd_bypass;
   logic [ADDR_SPACE-1:0] mem_waddr;
   logic [W-1:0]          mem_wdata;
   logic [Q-1:0]          mem_wlane;

   assign wr_fire   = !wsb && !clr_sel;
   assign rd_accept = ren && !clr_sel;
   assign rd_bypass = rd_accept && wr_fire && (raddr == waddr);

   // The sweep owns the write port whenever it runs.
   always_comb begin
      mem_waddr = waddr;
      mem_wdata = wdata;
      mem_wlane = {Q{wr_fire}} & ~bytemask;
      if (clr_sel) begin
         mem_waddr = clr_ptr;
         mem_wdata = {Q{INIT_VAL}};
         mem_wlane = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < Q; i++) begin
            if (mem_wlane[i]) mem[mem_waddr][i*BW +: BW] <= mem_wdata[i*BW +: BW];
         end
      end
   end

   logic [W-1:0] raw_reg;
   logic         byp_reg;
   logic [W-1:0] byp_data_reg;
   logic [W-1:0] byp_bits_reg;
   logic         rd_valid_reg;
   logic [W-1:0] rd_word;

   // Raw array read stays a plain registered read; the collision merge is applied after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         raw_reg      <= '0;
         byp_reg      <= 1'b0;
         byp_data_reg <= '0;
         byp_bits_reg <= '0;
         rd_valid_reg <= 1'b0;
      end else begin
         rd_valid_reg <= rd_accept;
         if (rd_accept) begin
            raw_reg      <= mem[raddr];
            byp_reg      <= rd_bypass;
            byp_data_reg <= wdata;
            byp_bits_reg <= wr_bits;
         end
      end
   end

   assign rd_word = byp_reg ? ((raw_reg & ~byp_bits_reg) | (byp_data_reg & byp_bits_reg)) : raw_reg;

`ifdef NEXT_SRAM_OUT_REG_EN
   logic [W-1:0] rdata_reg;
   logic         rvalid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
      end else begin
         rdata_reg  <= rd_word;
         rvalid_reg <= rd_valid_reg;
      end
   end

   assign rdata  = rdata_reg;
   assign rvalid = rvalid_reg;
`else
   assign rdata  = rd_word;
   assign rvalid = rd_valid_reg;
`endif

endmodule
